// File: rtl/writeback_unit_if.sv
// writeback_unit_if: MEM-stage, data-memory response and register-file write bundle
interface writeback_unit_if #(parameter int CNT_W = 64);
    logic             mem_valid;
    logic             wb_ready;
    logic             mem_reg_write;
    logic [4:0]       mem_rd_idx;
    logic [1:0]       mem_result_sel;
    logic [31:0]      mem_alu_result;
    logic [31:0]      mem_pc_plus4;
    logic [2:0]       mem_load_funct3;
    logic [1:0]       mem_addr_lo;
    logic             dmem_rvalid;
    logic [31:0]      dmem_rdata;
    logic             rf_wr_en;
    logic [4:0]       rf_wr_idx;
    logic [31:0]      rf_wr_data;
    logic             load_fault;
    logic [CNT_W-1:0] instret;
    modport slave (
        input  mem_valid, mem_reg_write, mem_rd_idx, mem_result_sel, mem_alu_result,
               mem_pc_plus4, mem_load_funct3, mem_addr_lo, dmem_rvalid, dmem_rdata,
        output wb_ready, rf_wr_en, rf_wr_idx, rf_wr_data, load_fault, instret
    );
    modport master (
        output mem_valid, mem_reg_write, mem_rd_idx, mem_result_sel, mem_alu_result,
               mem_pc_plus4, mem_load_funct3, mem_addr_lo, dmem_rvalid, dmem_rdata,
        input  wb_ready, rf_wr_en, rf_wr_idx, rf_wr_data, load_fault, instret
    );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: MEM/WB register, load response wait/alignment and retire counter
module writeback_unit #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 64
) (
    input logic            clk,
    input logic            rst,
    writeback_unit_if.slave bus
);
    localparam int TW = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [TW-1:0] LAST = TW'(LOAD_TIMEOUT - 1);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t           state, state_n;
    logic [TW-1:0]    cnt, cnt_n;
    logic             ld_we;
    logic [4:0]       ld_rd;
    logic [2:0]       ld_f3;
    logic [1:0]       ld_lo;
    logic             wr_en, fault;
    logic [4:0]       wr_idx, idx_n;
    logic [31:0]      wr_data, data_n, load_data;
    logic [CNT_W-1:0] retired;
    logic             accept, is_load, wr_n, fault_n, retire, bad_f3;
    logic [7:0]       b;
    logic [15:0]      h;
    assign bus.wb_ready   = (state == IDLE) && !rst;
    assign bus.rf_wr_en   = wr_en;
    assign bus.rf_wr_idx  = wr_idx;
    assign bus.rf_wr_data = wr_data;
    assign bus.load_fault = fault;
    assign bus.instret    = retired;
    assign accept  = bus.mem_valid && bus.wb_ready;
    assign is_load = bus.mem_result_sel == 2'b01;
    assign b       = 8'(bus.dmem_rdata >> {ld_lo, 3'b000});
    assign h       = 16'(bus.dmem_rdata >> {ld_lo[1], 4'b0000});
    assign bad_f3  = (ld_f3 == 3'b011) || (ld_f3[2:1] == 2'b11);
    // select and extend the addressed byte/half of the returning word
    always_comb begin
        case (ld_f3)
            3'b000:  load_data = {{24{b[7]}}, b};
            3'b001:  load_data = {{16{h[15]}}, h};
            3'b010:  load_data = bus.dmem_rdata;
            3'b100:  load_data = {24'd0, b};
            3'b101:  load_data = {16'd0, h};
            default: load_data = 32'd0;
        endcase
    end
    // next state, writeback request and retire decision
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wr_n    = 1'b0;
        idx_n   = wr_idx;
        data_n  = wr_data;
        fault_n = 1'b0;
        retire  = 1'b0;
        if (state == IDLE) begin
            if (accept && is_load) begin
                state_n = WAIT;
                cnt_n   = '0;
            end else if (accept) begin
                retire = 1'b1;
                wr_n   = bus.mem_reg_write && (bus.mem_rd_idx != 5'd0);
                idx_n  = wr_n ? bus.mem_rd_idx : wr_idx;
                data_n = !wr_n ? wr_data :
                         (bus.mem_result_sel == 2'b10) ? bus.mem_pc_plus4 : bus.mem_alu_result;
            end
        end else if (bus.dmem_rvalid) begin
            state_n = IDLE;
            retire  = 1'b1;
            wr_n    = ld_we && (ld_rd != 5'd0);
            idx_n   = wr_n ? ld_rd : wr_idx;
            data_n  = wr_n ? load_data : wr_data;
            fault_n = bad_f3;
        end else if (cnt == LAST) begin
            state_n = IDLE;
            fault_n = 1'b1;
        end else begin
            cnt_n = cnt + 1'b1;
        end
    end
    // state and timeout counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // load context latch, writeback outputs and retire count
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_we   <= 1'b0;
            ld_rd   <= 5'd0;
            ld_f3   <= 3'd0;
            ld_lo   <= 2'd0;
            wr_en   <= 1'b0;
            wr_idx  <= 5'd0;
            wr_data <= 32'd0;
            fault   <= 1'b0;
            retired <= '0;
        end else begin
            if (accept && is_load) begin
                ld_we <= bus.mem_reg_write;
                ld_rd <= bus.mem_rd_idx;
                ld_f3 <= bus.mem_load_funct3;
                ld_lo <= bus.mem_addr_lo;
            end
            wr_en   <= wr_n;
            wr_idx  <= idx_n;
            wr_data <= data_n;
            fault   <= fault_n;
            if (retire) retired <= retired + 1'b1;
        end
    end
endmodule
